// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 (optionally 8E1) UART transmitter.
//   Bytes written with tf_push/tf_data are buffered in a FIFO_DEPTH-entry
//   FIFO and serialized LSB first onto the idle-high line tx.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high, clears all state
//   tf_push    - write strobe, one byte per high cycle
//   tf_data    - byte written when tf_push=1
//   tx         - serial line, idle high (registered)
//   fifo_full  - FIFO holds FIFO_DEPTH bytes (registered)
//   fifo_empty - FIFO holds no bytes (registered)
//   busy       - frame in progress or bytes pending (registered)
//   overflow   - sticky, a push was dropped while full (registered)
// Configuration macro:
//   UART_TX_PARITY_EN - when defined, an even parity bit follows the data bits.
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tf_push,
    input  logic [7:0] tf_data,
    output logic       tx,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned DIV = CLK_FREQ_HZ / BAUD;
    localparam int unsigned BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  w_count_nxt;

    logic [7:0]     r_shift;
    logic [2:0]     r_bit;
    logic [BW-1:0]  r_baud;
`ifdef UART_TX_PARITY_EN
    logic           r_par;
`endif

    logic           r_tx;
    logic           r_full;
    logic           r_empty;
    logic           r_busy;
    logic           r_ovf;

    logic           w_tick;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic           w_do_push;
    logic           w_do_pop;
    logic           w_tx;

    assign w_fifo_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_fifo_empty = (r_count == '0);
    assign w_tick       = (r_baud == BW'(DIV - 1));
    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign w_do_push    = tf_push && !w_fifo_full;
    assign w_do_pop     = !w_fifo_empty &&
                          ((r_state == S_IDLE) || ((r_state == S_STOP) && w_tick));

    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (!w_fifo_empty) w_state_nxt = S_START;
            S_START:  if (w_tick) w_state_nxt = S_DATA;
            S_DATA:   if (w_tick && (r_bit == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                          w_state_nxt = S_PARITY;
`else
                          w_state_nxt = S_STOP;
`endif
                      end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (w_tick) w_state_nxt = S_STOP;
`endif
            S_STOP:   if (w_tick) w_state_nxt = w_fifo_empty ? S_IDLE : S_START;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: output logic (line level, registered below)
    always_comb begin
        w_tx = 1'b1;
        unique case (r_state)
            S_IDLE:   w_tx = 1'b1;
            S_START:  w_tx = 1'b0;
            S_DATA:   w_tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx = r_par;
`endif
            S_STOP:   w_tx = 1'b1;
            default:  w_tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= tf_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_shift  <= '0;
            r_bit    <= '0;
            r_baud   <= '0;
`ifdef UART_TX_PARITY_EN
            r_par    <= 1'b0;
`endif
            r_tx     <= 1'b1;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_nxt;
            if (tf_push && w_fifo_full) r_ovf <= 1'b1;

            // Every tick ends a state or a data bit, so the counter restarts on it.
            if ((r_state == S_IDLE) || w_tick) r_baud <= '0;
            else                               r_baud <= r_baud + BW'(1);

            if (w_do_pop) begin
                r_shift <= r_mem[r_rd_ptr];
                r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
                r_par   <= ^r_mem[r_rd_ptr];
`endif
            end else if ((r_state == S_DATA) && w_tick) begin
                r_shift <= {1'b0, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end

            r_tx    <= w_tx;
            r_full  <= (w_count_nxt == CW'(FIFO_DEPTH));
            r_empty <= (w_count_nxt == '0);
            r_busy  <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
        end
    end

    assign tx         = r_tx;
    assign fifo_full  = r_full;
    assign fifo_empty = r_empty;
    assign busy       = r_busy;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo at DIV=10.
//   A background monitor decodes line frames into a queue; the tests compare
//   those frames and the status flags against hand-computed values.
module tb_uart_tx_fifo;

    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * DIV;
`else
    localparam int FRAME = 10 * DIV;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       tf_push;
    logic [7:0] tf_data;
    logic       tx, fifo_full, fifo_empty, busy, overflow;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int last_push_cyc;

    typedef struct {
        logic [9:0] frame;   // {stop, data[7:0], start}
        logic       par;
        int         start_cyc;
    } rx_t;
    rx_t rxq[$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;
    vec_t vecs[5];

    uart_tx_fifo #(
        .CLK_FREQ_HZ(1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tf_push   (tf_push),
        .tf_data   (tf_data),
        .tx        (tx),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: sample each bit in its middle.
    initial begin
        rx_t r;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                r.start_cyc = cyc;
                r.par = 1'b0;
                repeat (DIV / 2) @(negedge clk);
                r.frame[0] = tx;
                for (int i = 1; i <= 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    r.frame[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (DIV) @(negedge clk);
                r.par = tx;
`endif
                repeat (DIV) @(negedge clk);
                r.frame[9] = tx;
                rxq.push_back(r);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [7:0] d);
        tf_push = 1'b1;
        tf_data = d;
        @(negedge clk);
        last_push_cyc = cyc;
        tf_push = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int b;
        b = budget;
        while (rxq.size() < n && b > 0) begin
            @(negedge clk);
            b--;
        end
        check("frames_received", rxq.size(), n);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        int e;
        vecs[0] = '{data: 8'h55, frame: 10'h2AA};
        vecs[1] = '{data: 8'h00, frame: 10'h200};
        vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
        vecs[3] = '{data: 8'hA5, frame: 10'h34A};
        vecs[4] = '{data: 8'h07, frame: 10'h20E};

        reset = 1'b1;
        tf_push = 1'b0;
        tf_data = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_full", fifo_full, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single bytes: frame shape, latency, busy window
        for (int v = 0; v < 5; v++) begin
            rxq.delete();
            push(vecs[v].data);
            e = last_push_cyc;
            check("vec_busy_on", busy, 1);
            check("vec_not_empty", fifo_empty, 0);
            wait_frames(1, FRAME + 20);
            if (rxq.size() > 0) begin
                check("vec_frame", rxq[0].frame, vecs[v].frame);
                check("vec_latency", rxq[0].start_cyc - e, 2);
            end
            wait_until(e + FRAME);
            check("vec_busy_hold", busy, 1);
            @(negedge clk);
            check("vec_busy_off", busy, 0);
            check("vec_empty", fifo_empty, 1);
        end

        // Back-to-back frames, no idle gap between STOP and START
        rxq.delete();
        push(8'h00);
        e = last_push_cyc;
        push(8'hFF);
        wait_frames(2, 2 * FRAME + 20);
        if (rxq.size() == 2) begin
            check("b2b_f0", rxq[0].frame, 10'h200);
            check("b2b_f1", rxq[1].frame, 10'h3FE);
            check("b2b_gap", rxq[1].start_cyc - rxq[0].start_cyc, FRAME);
        end
        wait_until(e + 2 * FRAME);
        check("b2b_busy_hold", busy, 1);
        @(negedge clk);
        check("b2b_busy_off", busy, 0);

        // 17 consecutive pushes: first pop frees a slot, nothing dropped
        rxq.delete();
        for (int i = 1; i <= 17; i++) push(8'(i));
        check("burst_full", fifo_full, 1);
        check("burst_ovf", overflow, 0);
        wait_frames(17, 17 * FRAME + 50);
        for (int i = 0; i < 17 && i < rxq.size(); i++)
            check("burst_frame", rxq[i].frame, {1'b1, 8'(i + 1), 1'b0});
        check("burst_ovf_end", overflow, 0);

        // Fill while a frame is on the line, then overflow
        rxq.delete();
        push(8'h80);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 16; i++) push(8'h90 + 8'(i));
        check("fill_full", fifo_full, 1);
        check("fill_ovf0", overflow, 0);
        push(8'hAA);
        check("drop_ovf", overflow, 1);
        check("drop_full", fifo_full, 1);
        wait_frames(17, 17 * FRAME + 50);
        repeat (FRAME + 20) @(negedge clk);
        check("drop_count", rxq.size(), 17);
        if (rxq.size() > 0) check("drop_first", rxq[0].frame, 10'h300);
        for (int i = 1; i < 17 && i < rxq.size(); i++)
            check("drop_frame", rxq[i].frame, {1'b1, 8'h90 + 8'(i - 1), 1'b0});
        check("ovf_sticky", overflow, 1);
        check("drop_empty", fifo_empty, 1);

        // Reset in the middle of data bit 3 of 0xC3
        rxq.delete();
        push(8'hC3);
        e = last_push_cyc;
        wait_until(e + 2 + DIV + 3 * DIV + DIV / 2);
        check("mid_bit3", tx, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_empty", fifo_empty, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ovf", overflow, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (FRAME + 20) @(negedge clk);
        check("post_rst_tx", tx, 1);
        rxq.delete();
        push(8'h3C);
        e = last_push_cyc;
        wait_frames(1, FRAME + 20);
        if (rxq.size() > 0) begin
            check("post_rst_frame", rxq[0].frame, 10'h278);
            check("post_rst_latency", rxq[0].start_cyc - e, 2);
        end

        // Frame length (and parity bit when enabled)
        repeat (FRAME) @(negedge clk);
        rxq.delete();
        push(8'h07);
        push(8'h07);
        wait_frames(2, 2 * FRAME + 20);
        if (rxq.size() == 2) begin
            check("len_gap", rxq[1].start_cyc - rxq[0].start_cyc, FRAME);
`ifdef UART_TX_PARITY_EN
            check("parity_07", rxq[0].par, 1);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
